multi_timer: RTL



---
 rtl/multi_timer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// Multi-channel bus timer: per-channel prescaler, up/down count, one-shot/periodic,
// sticky W1C expiry flag and a combined registered interrupt.
module multi_timer #(
  parameter int unsigned CH = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rest,
  input  logic          cs,
  input  logic          as,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic          rdy,
  output logic [DW-1:0] rd_data,
  output logic          irq
);

  localparam int unsigned IW = AW - 2;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_LOAD  = 2'd1,
    REG_COUNT = 2'd2,
    REG_STAT  = 2'd3
  } reg_e;

  logic [CH-1:0] start_q, start_d, dir_q, dir_d, per_q, per_d;
  logic [CH-1:0] ien_q, ien_d, pend_q, pend_d;
  logic [7:0]    psc_q [CH];
  logic [7:0]    psc_d [CH];
  logic [7:0]    pre_q [CH];
  logic [7:0]    pre_d [CH];
  logic [DW-1:0] load_q [CH];
  logic [DW-1:0] load_d [CH];
  logic [DW-1:0] cnt_q [CH];
  logic [DW-1:0] cnt_d [CH];
  logic          rdy_q, irq_q;
  logic [DW-1:0] rd_q, rd_d;

  logic          acc, wr;
  logic [CH-1:0] sel, tick, expire;
  reg_e          rsel;

  // Channel decode by equality so indices >= CH select nothing (reads 0, writes dropped).
  always_comb begin
    acc  = cs & as;
    wr   = acc & ~rw;
    rsel = reg_e'(addr[1:0]);
    sel  = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      sel[i] = (addr[AW-1:2] == IW'(i));
    end
  end

  always_comb begin
    tick   = '0;
    expire = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      tick[i]   = start_q[i] && (pre_q[i] == psc_q[i]);
      expire[i] = start_q[i] && (pre_q[i] == psc_q[i]) &&
                  (dir_q[i] ? (cnt_q[i] == '0) : (cnt_q[i] == load_q[i]));
    end
  end

  // Order matters: W1C, then tick/expiry, then bus writes, so later steps win.
  always_comb begin
    start_d = start_q;
    dir_d   = dir_q;
    per_d   = per_q;
    ien_d   = ien_q;
    pend_d  = pend_q;
    psc_d   = psc_q;
    pre_d   = pre_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < CH; i++) begin
      if (wr && sel[i] && rsel == REG_STAT && wr_data[0]) pend_d[i] = 1'b0;
      if (start_q[i]) pre_d[i] = tick[i] ? '0 : pre_q[i] + 8'd1;
      if (tick[i]) begin
        if (expire[i]) begin
          pend_d[i] = 1'b1;
          if (per_q[i]) cnt_d[i] = dir_q[i] ? load_q[i] : '0;
          else          start_d[i] = 1'b0;
        end else begin
          cnt_d[i] = dir_q[i] ? cnt_q[i] - DW'(1) : cnt_q[i] + DW'(1);
        end
      end
      if (wr && sel[i]) begin
        case (rsel)
          REG_CTRL: begin
            start_d[i] = wr_data[0];
            dir_d[i]   = wr_data[1];
            per_d[i]   = wr_data[2];
            ien_d[i]   = wr_data[3];
            psc_d[i]   = wr_data[15:8];
            cnt_d[i]   = cnt_q[i];
            if (wr_data[0] && !start_q[i]) begin
              cnt_d[i] = wr_data[1] ? load_q[i] : '0;
              pre_d[i] = '0;
            end
          end
          REG_LOAD:  load_d[i] = wr_data;
          REG_COUNT: cnt_d[i]  = wr_data;
          REG_STAT:  ;
        endcase
      end
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (acc && rw) begin
      rd_d = '0;
      for (int unsigned i = 0; i < CH; i++) begin
        if (sel[i]) begin
          case (rsel)
            REG_CTRL:  rd_d[15:0] = {psc_q[i], 4'b0000, ien_q[i], per_q[i], dir_q[i], start_q[i]};
            REG_LOAD:  rd_d = load_q[i];
            REG_COUNT: rd_d = cnt_q[i];
            REG_STAT:  rd_d[1:0] = {start_q[i], pend_q[i]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      start_q <= '0;
      dir_q   <= '0;
      per_q   <= '0;
      ien_q   <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        psc_q[i]  <= '0;
        pre_q[i]  <= '0;
        load_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      rdy_q <= 1'b0;
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      start_q <= start_d;
      dir_q   <= dir_d;
      per_q   <= per_d;
      ien_q   <= ien_d;
      pend_q  <= pend_d;
      psc_q   <= psc_d;
      pre_q   <= pre_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      rdy_q   <= acc;
      rd_q    <= rd_d;
      irq_q   <= |(pend_q & ien_q);
    end
  end

  assign rdy     = rdy_q;
  assign rd_data = rd_q;
  assign irq     = irq_q;

endmodule
